// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - pin-level 16-bit asynchronous SRAM responder backed by a block-RAM store
//
// Purpose:
//   The FPGA behaves as an asynchronous SRAM chip for an external initiator.
//   Every pin input is synchronised into the clk domain. The synchronised
//   strobes are decoded into reads and writes against an internal word store.
//   The shared data bus is driven through SB_IO tristate controls.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   address_pins  18-bit address from the initiator (bits >= ADDR_WIDTH alias)
//   data_pins_in  SB_IO D_IN_0 of the data pins
//   data_pins_out SB_IO D_OUT_0 of the data pins
//   set_data_pins SB_IO OUTPUT_ENABLE, 1 = responder drives the bus
//   CS, OE, WE    active-low chip select, output enable, write enable
//   write_count   committed writes, saturating
//   read_count    read accesses started, saturating

module sram_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [17:0]           address_pins,
  input  logic [DATA_WIDTH-1:0] data_pins_in,
  output logic [DATA_WIDTH-1:0] data_pins_out,
  output logic                  set_data_pins,
  input  logic                  CS,
  input  logic                  OE,
  input  logic                  WE,
  output logic [15:0]           write_count,
  output logic [15:0]           read_count
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } state_t;

  // Synchroniser chains. The strobes are packed as {CS, OE, WE}.
  logic [2:0]            strb_sync_q [SYNC_STAGES];
  logic [2:0]            strb_sync_d [SYNC_STAGES];
  logic [17:0]           addr_sync_q [SYNC_STAGES];
  logic [17:0]           addr_sync_d [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] data_sync_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] data_sync_d [SYNC_STAGES];

  logic                  cs_s, oe_s, we_s;
  logic [17:0]           addr_s;
  logic [DATA_WIDTH-1:0] data_s;
  logic                  rd_req, wr_act;

  state_t                state_q, state_d;
  logic [17:0]           rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  set_q, set_d;
  logic [15:0]           wc_q, wc_d;
  logic [15:0]           rc_q, rc_d;
  logic                  rd_en;
  logic                  mem_we;

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] mem_rdata_q;

  always_comb begin
    strb_sync_d[0] = {CS, OE, WE};
    addr_sync_d[0] = address_pins;
    data_sync_d[0] = data_pins_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      strb_sync_d[i] = strb_sync_q[i-1];
      addr_sync_d[i] = addr_sync_q[i-1];
      data_sync_d[i] = data_sync_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        strb_sync_q[i] <= 3'b111;
        addr_sync_q[i] <= '0;
        data_sync_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        strb_sync_q[i] <= strb_sync_d[i];
        addr_sync_q[i] <= addr_sync_d[i];
        data_sync_q[i] <= data_sync_d[i];
      end
    end
  end

  assign cs_s   = strb_sync_q[SYNC_STAGES-1][2];
  assign oe_s   = strb_sync_q[SYNC_STAGES-1][1];
  assign we_s   = strb_sync_q[SYNC_STAGES-1][0];
  assign addr_s = addr_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];

  // WE low wins over OE, so a write can never turn the bus around.
  assign rd_req = !cs_s && !oe_s && we_s;
  assign wr_act = !cs_s && !we_s;

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    dout_d    = dout_q;
    set_d     = 1'b0;
    wc_d      = wc_q;
    rc_d      = rc_q;
    rd_en     = 1'b0;
    mem_we    = 1'b0;

    // Keep sampling the bus while the write is active; the last sample commits.
    if (wr_act) begin
      wr_addr_d = addr_s[ADDR_WIDTH-1:0];
      wr_data_d = data_s;
    end

    case (state_q)
      IDLE: begin
        if (wr_act) begin
          state_d = WRITE;
        end else if (rd_req) begin
          state_d   = READ;
          rd_en     = 1'b1;
          rd_addr_d = addr_s;
          if (rc_q != 16'hFFFF) rc_d = rc_q + 16'd1;
        end
      end
      READ: begin
        if (rd_req) begin
          set_d  = 1'b1;
          dout_d = mem_rdata_q;
          // The full address is compared so an aliasing step re-reads too.
          if (addr_s != rd_addr_q) begin
            rd_en     = 1'b1;
            rd_addr_d = addr_s;
          end
        end else begin
          state_d = wr_act ? WRITE : IDLE;
        end
      end
      WRITE: begin
        if (!wr_act) begin
          mem_we  = 1'b1;
          state_d = IDLE;
          if (wc_q != 16'hFFFF) wc_d = wc_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      dout_q    <= '0;
      set_q     <= 1'b0;
      wc_q      <= '0;
      rc_q      <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      dout_q    <= dout_d;
      set_q     <= set_d;
      wc_q      <= wc_d;
      rc_q      <= rc_d;
    end
  end

  // Block-RAM store: no reset, contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr_q] <= wr_data_q;
    if (rd_en)  mem_rdata_q <= mem[rd_addr_d[ADDR_WIDTH-1:0]];
  end

  assign data_pins_out = dout_q;
  // Gating on the synchronised strobes removes the one-cycle window in which
  // the registered enable could still be high after WE falls or CS rises.
  assign set_data_pins = set_q && we_s && !cs_s;
  assign write_count   = wc_q;
  assign read_count    = rc_q;

endmodule

// File: tb/tb_sram_responder.sv
// tb/tb_sram_responder.sv - directed self-checking bench for sram_responder
module tb_sram_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [17:0] address_pins;
  logic [15:0] data_pins_in;
  logic [15:0] data_pins_out;
  logic        set_data_pins;
  logic        CS, OE, WE;
  logic [15:0] write_count;
  logic [15:0] read_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sram_responder #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (16),
    .SYNC_STAGES(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .address_pins (address_pins),
    .data_pins_in (data_pins_in),
    .data_pins_out(data_pins_out),
    .set_data_pins(set_data_pins),
    .CS           (CS),
    .OE           (OE),
    .WE           (WE),
    .write_count  (write_count),
    .read_count   (read_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges; inputs are driven and outputs sampled at the falling edge.
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic write_word(input logic [17:0] a, input logic [15:0] d);
    address_pins = a;
    data_pins_in = d;
    CS = 1'b0;
    WE = 1'b0;
    cycles(4);
    WE = 1'b1;
    CS = 1'b1;
    cycles(5);
  endtask

  task automatic release_bus();
    CS = 1'b1;
    OE = 1'b1;
    cycles(4);
  endtask

  initial begin
    reset        = 1'b1;
    address_pins = '0;
    data_pins_in = '0;
    CS = 1'b1; OE = 1'b1; WE = 1'b1;
    cycles(3);
    check("rst_set", set_data_pins, 1'b0);
    check("rst_dout", data_pins_out, 16'h0000);
    check("rst_wc", write_count, 16'd0);
    check("rst_rc", read_count, 16'd0);
    reset = 1'b0;
    cycles(2);

    write_word(18'h00005, 16'h1234);
    check("wr5_wc", write_count, 16'd1);
    write_word(18'h00006, 16'hBEEF);
    check("wr6_wc", write_count, 16'd2);

    // Read 0x05: bus must be driven at edge 4, not before.
    address_pins = 18'h00005;
    CS = 1'b0; OE = 1'b0;
    cycles(3);
    check("rd5_set_e3", set_data_pins, 1'b0);
    cycles(1);
    check("rd5_set_e4", set_data_pins, 1'b1);
    check("rd5_dout", data_pins_out, 16'h1234);
    check("rd5_rc", read_count, 16'd1);

    // Address step while the read holds.
    address_pins = 18'h00006;
    cycles(3);
    check("step_dout_e3", data_pins_out, 16'h1234);
    check("step_set_e3", set_data_pins, 1'b1);
    cycles(1);
    check("step_dout_e4", data_pins_out, 16'hBEEF);
    check("step_set_e4", set_data_pins, 1'b1);
    check("step_rc", read_count, 16'd1);
    release_bus();
    check("rel_set", set_data_pins, 1'b0);

    // Aliasing: 0x00101 lands on word 0x01.
    write_word(18'h00101, 16'hAAAA);
    check("alias_wc", write_count, 16'd3);
    address_pins = 18'h00001;
    CS = 1'b0; OE = 1'b0;
    cycles(4);
    check("alias_set", set_data_pins, 1'b1);
    check("alias_dout", data_pins_out, 16'hAAAA);
    check("alias_rc", read_count, 16'd2);
    release_bus();

    // OE and WE together: write wins, then the read follows on WE release.
    address_pins = 18'h00010;
    data_pins_in = 16'h5A5A;
    CS = 1'b0; OE = 1'b0; WE = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycles(1);
      check("oewe_set_low", set_data_pins, 1'b0);
    end
    WE = 1'b1;
    cycles(3);
    check("oewe_wc", write_count, 16'd4);
    check("oewe_set_e3", set_data_pins, 1'b0);
    cycles(2);
    check("oewe_set_e5", set_data_pins, 1'b1);
    check("oewe_dout", data_pins_out, 16'h5A5A);
    check("oewe_rc", read_count, 16'd3);
    release_bus();

    // Reset during a write discards it.
    write_word(18'h00020, 16'h1111);
    check("pre_wc", write_count, 16'd5);
    address_pins = 18'h00020;
    data_pins_in = 16'h2222;
    CS = 1'b0; WE = 1'b0;
    cycles(4);
    reset = 1'b1;
    #1;
    check("midwr_rst_wc", write_count, 16'd0);
    WE = 1'b1; CS = 1'b1;
    cycles(3);
    reset = 1'b0;
    cycles(4);
    check("midwr_wc", write_count, 16'd0);
    address_pins = 18'h00020;
    CS = 1'b0; OE = 1'b0;
    cycles(4);
    check("midwr_set", set_data_pins, 1'b1);
    check("midwr_dout", data_pins_out, 16'h1111);
    check("midwr_rc", read_count, 16'd1);

    // Reset during a read releases the bus immediately.
    reset = 1'b1;
    #1;
    check("rdrst_set", set_data_pins, 1'b0);
    check("rdrst_dout", data_pins_out, 16'h0000);
    CS = 1'b1; OE = 1'b1;
    cycles(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Pin-level responder for the 16-bit asynchronous SRAM bus: the FPGA behaves as the SRAM chip for an external initiator driving CS/OE/WE/address/data.
- Synchronises the active-low strobes, address and data into the clk domain.
- Backs the bus with an internal block-RAM word store.
- Drives the shared data bus through the SB_IO tristate controls (data_pins_out, set_data_pins). Used as a bench target for the sram controller and as a standalone memory emulator.

Parameters:
ADDR_WIDTH, 8, implemented address bits; the store is 2**ADDR_WIDTH words and upper address_pins bits are ignored (aliasing)
DATA_WIDTH, 16, word width; must match the data pin count
SYNC_STAGES, 2, flop stages on every pin input (minimum 2)

Ports:
clk  input  1  system clock (12 MHz board clock)
reset  input  1  asynchronous, active-high reset
address_pins  input  18  SRAM address bus from initiator
data_pins_in  input  DATA_WIDTH  SB_IO D_IN_0 of the data pins
data_pins_out  output  DATA_WIDTH  SB_IO D_OUT_0 of the data pins
set_data_pins  output  1  SB_IO OUTPUT_ENABLE; 1 = responder drives the bus
CS  input  1  chip select, active low
OE  input  1  output enable, active low
WE  input  1  write enable, active low
write_count  output  16  committed writes, saturating at 16'hFFFF
read_count  output  16  read accesses started, saturating at 16'hFFFF

Behaviour:
- Reset (async, active-high):
  - data_pins_out=0, set_data_pins=0, counters=0, state=IDLE.
  - Sync flops load 1 for CS/OE/WE and 0 for address/data.
  - Store contents are not cleared; they initialise to 0 at configuration.
- Synchronisation: all pin inputs pass SYNC_STAGES flops. "_s" below denotes the synchronised value, which lags the pins by SYNC_STAGES cycles.
- Decode on synchronised values:
  - rd_req = !CS_s && !OE_s && WE_s.
  - wr_act = !CS_s && !WE_s.
  - WE low overrides OE: a write never drives the bus.
- States: IDLE, READ, WRITE.
- IDLE:
  - wr_act -> WRITE.
  - Else rd_req -> READ: issue a store read of address_s[ADDR_WIDTH-1:0], latch it as rd_addr, and increment read_count.
  - set_data_pins=0.
- READ:
  - The store output is registered into data_pins_out one cycle after the read issues. set_data_pins goes 1 on that same edge, i.e. bus driven SYNC_STAGES+2 clk edges after the pin transition.
  - If address_s changes while rd_req holds, re-read the new address. data_pins_out updates one cycle later and set_data_pins stays 1. read_count is not incremented.
  - rd_req drops -> set_data_pins=0 on the next edge and state returns to IDLE. If wr_act is already true at that point, go straight to WRITE.
- WRITE:
  - Every cycle wr_act holds, register wr_addr=address_s and wr_data=data_pins_in_s.
  - The cycle wr_act falls (WE_s or CS_s rising, or both together): write mem[wr_addr]=wr_data exactly once and increment write_count.
  - Then go to IDLE; a simultaneous rd_req is handled from IDLE next cycle.
  - set_data_pins=0 throughout.
- Address wrap: address_pins bits above ADDR_WIDTH-1 are ignored; address 0x00100 aliases 0x00000 when ADDR_WIDTH=8.
- Counters: 16-bit, saturate at 16'hFFFF, no wrap.
- Reset mid-operation:
  - During WRITE: the pending write is discarded.
  - During READ: the bus is released immediately (set_data_pins=0 asynchronously).
- Bus-contention rule: set_data_pins must be 0 whenever WE_s=0 or CS_s=1.

Test Plan:
- Reset with strobes high -> set_data_pins=0, data_pins_out=0, write_count=0, read_count=0.
- Write 0x1234 to address 0x05 (CS=0, WE=0 for 4 cycles, then WE=1) -> write_count=1. Then read 0x05 (CS=0, OE=0) -> set_data_pins=1 at edge SYNC_STAGES+2, data_pins_out=0x1234, read_count=1.
- Read held with the address stepping 0x05 -> 0x06 (holding 0xBEEF) -> data_pins_out changes to 0xBEEF one cycle after address_s changes; read_count remains 1 and set_data_pins stays 1.
- Write 0xAAAA to 0x00101 with ADDR_WIDTH=8, then read 0x01 -> 0xAAAA (alias).
- OE=0 and WE=0 asserted together -> set_data_pins never 1; on WE release one write commits, then a read starts and drives the written value.
- Assert reset during a write (WE still low) -> no store update, write_count=0, and a later read of that address returns the prior contents.
